// File: rtl/softmax_dat_feeder_if.sv
// Read-master and softmax-stream bundle of the feature-map feeder.
// master = feeder side, slave = memory/softmax side.
interface softmax_dat_feeder_if #(
  parameter int DAT_DW     = 16,
  parameter int TOUT       = 8,
  parameter int LOG2_BURST = 3,
  parameter int CH_W       = 12,
  parameter int AW         = 32
);
  logic                   rd_req_vld;
  logic                   rd_req_rdy;
  logic [AW-1:0]          rd_req_addr;
  logic [DAT_DW*TOUT-1:0] rd_resp_dat;
  logic                   rd_resp_vld;
  logic                   rd_resp_rdy;
  logic [DAT_DW*TOUT-1:0] dat_out;
  logic                   dat_out_vld;
  logic                   dat_out_rdy;
  logic [LOG2_BURST-1:0]  wr_addr;
  logic [CH_W-1:0]        ch_addr;

  modport master (
    output rd_req_vld,
    output rd_req_addr,
    input  rd_req_rdy,
    input  rd_resp_dat,
    input  rd_resp_vld,
    output rd_resp_rdy,
    output dat_out,
    output dat_out_vld,
    output wr_addr,
    output ch_addr,
    input  dat_out_rdy
  );

  modport slave (
    input  rd_req_vld,
    input  rd_req_addr,
    output rd_req_rdy,
    output rd_resp_dat,
    output rd_resp_vld,
    input  rd_resp_rdy,
    input  dat_out,
    input  dat_out_vld,
    input  wr_addr,
    input  ch_addr,
    output dat_out_rdy
  );
endinterface

// File: rtl/softmax_dat_feeder.sv
// Walks a feature map (pixel group, channel group, lane), issues word
// reads and forwards the in-order responses tagged with lane/group.
module softmax_dat_feeder #(
  parameter int DAT_DW     = 16,
  parameter int TOUT       = 8,
  parameter int BURST_LEN  = 8,
  parameter int LOG2_BURST = 3,
  parameter int CH_W       = 12,
  parameter int PIX_W      = 16,
  parameter int AW         = 32,
  parameter int OUTSTD     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [CH_W-1:0]  ch_in,
  input  logic [PIX_W-1:0] pixel_num,
  output logic             busy,
  output logic             done,
  softmax_dat_feeder_if.master bus
);

  localparam int DW        = DAT_DW * TOUT;
  localparam int LOG2_TOUT = $clog2(TOUT);
  localparam int LOG2_OUT  = $clog2(OUTSTD);
  localparam int CNT_W     = LOG2_OUT + 1;
  localparam int TAG_W     = LOG2_BURST + CH_W;
  localparam int PX_W      = PIX_W + 2;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [PIX_W-1:0]      pn_q, pn_d;
  logic [CH_W-1:0]       chg_q, chg_d;
  logic [AW-1:0]         grp_q, grp_d;
  logic [AW-1:0]         row_q, row_d;
  logic [PX_W-1:0]       gpix_q, gpix_d;
  logic [CH_W-1:0]       c_q, c_d;
  logic [LOG2_BURST-1:0] p_q, p_d;

  logic [TAG_W-1:0]      tag_q [OUTSTD];
  logic [TAG_W-1:0]      tag_d [OUTSTD];
  logic [LOG2_OUT-1:0]   wp_q, wp_d;
  logic [LOG2_OUT-1:0]   rp_q, rp_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  full_q, full_d;
  logic [DW-1:0]         dat_q, dat_d;
  logic [LOG2_BURST-1:0] wr_q, wr_d;
  logic [CH_W-1:0]       ch_q, ch_d;

  logic [CH_W:0]         ch_sum;
  logic [CH_W-1:0]       chg_calc;
  logic                  tag_full;
  logic                  tag_empty;
  logic                  req_vld;
  logic                  resp_rdy;
  logic                  push;
  logic                  pop;
  logic [PX_W-1:0]       lane_nxt;
  logic [PX_W-1:0]       gpix_nxt;
  logic                  last_lane;
  logic                  last_chg;
  logic                  last_grp;

  assign ch_sum   = {1'b0, ch_in} + (CH_W+1)'(TOUT-1);
  assign chg_calc = CH_W'(ch_sum >> LOG2_TOUT);

  assign tag_full  = (cnt_q == CNT_W'(OUTSTD));
  assign tag_empty = (cnt_q == '0);
  assign req_vld   = (state_q == REQ) && !tag_full;
  // A stray beat with no tag is still accepted so it can be dropped.
  assign resp_rdy  = tag_empty || !full_q || bus.dat_out_rdy;
  assign push      = req_vld && bus.rd_req_rdy;
  assign pop       = bus.rd_resp_vld && resp_rdy && !tag_empty;

  // Lanes past pixel_num only ever trail a group, so the walk
  // jumps straight to the next group when the next lane is out.
  assign lane_nxt  = gpix_q + PX_W'(p_q) + PX_W'(1);
  assign gpix_nxt  = gpix_q + PX_W'(BURST_LEN);
  assign last_lane = (p_q == LOG2_BURST'(BURST_LEN-1)) ||
                     (lane_nxt >= PX_W'(pn_q));
  assign last_chg  = (c_q == chg_q - 1'b1);
  assign last_grp  = (gpix_nxt >= PX_W'(pn_q));

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pn_d    = pn_q;
    chg_d   = chg_q;
    grp_d   = grp_q;
    row_d   = row_q;
    gpix_d  = gpix_q;
    c_d     = c_q;
    p_d     = p_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          busy_d  = 1'b1;
          pn_d    = pixel_num;
          chg_d   = chg_calc;
          grp_d   = base_addr;
          row_d   = base_addr;
          gpix_d  = '0;
          c_d     = '0;
          p_d     = '0;
          if ((ch_in == '0) || (pixel_num == '0))
            state_d = DONE;
          else
            state_d = REQ;
        end
      end
      REQ: begin
        if (push) begin
          if (!last_lane) begin
            p_d = p_q + 1'b1;
          end else begin
            p_d = '0;
            if (!last_chg) begin
              c_d   = c_q + 1'b1;
              row_d = row_q + AW'(pn_q);
            end else begin
              c_d = '0;
              if (last_grp) begin
                state_d = DRAIN;
              end else begin
                gpix_d = gpix_nxt;
                grp_d  = grp_q + AW'(BURST_LEN);
                row_d  = grp_q + AW'(BURST_LEN);
              end
            end
          end
        end
      end
      DRAIN: begin
        if (tag_empty && !full_q)
          state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tag_d  = tag_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    full_d = full_q;
    dat_d  = dat_q;
    wr_d   = wr_q;
    ch_d   = ch_q;
    if (push) begin
      tag_d[wp_q] = {p_q, c_q};
      wp_d        = wp_q + 1'b1;
    end
    if (pop)
      rp_d = rp_q + 1'b1;
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    if (pop) begin
      full_d       = 1'b1;
      dat_d        = bus.rd_resp_dat;
      {wr_d, ch_d} = tag_q[rp_q];
    end else if (bus.dat_out_rdy) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pn_q    <= '0;
      chg_q   <= '0;
      grp_q   <= '0;
      row_q   <= '0;
      gpix_q  <= '0;
      c_q     <= '0;
      p_q     <= '0;
      for (int i = 0; i < OUTSTD; i++)
        tag_q[i] <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      dat_q   <= '0;
      wr_q    <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pn_q    <= pn_d;
      chg_q   <= chg_d;
      grp_q   <= grp_d;
      row_q   <= row_d;
      gpix_q  <= gpix_d;
      c_q     <= c_d;
      p_q     <= p_d;
      tag_q   <= tag_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      dat_q   <= dat_d;
      wr_q    <= wr_d;
      ch_q    <= ch_d;
    end
  end

  assign bus.rd_req_vld  = req_vld;
  assign bus.rd_req_addr = row_q + AW'(p_q);
  assign bus.rd_resp_rdy = resp_rdy;
  assign bus.dat_out     = dat_q;
  assign bus.dat_out_vld = full_q;
  assign bus.wr_addr     = wr_q;
  assign bus.ch_addr     = ch_q;
  assign busy            = busy_q;
  assign done            = done_q;

  a_resp_has_tag: assert property (
    @(posedge clk) disable iff (rst)
    !(bus.rd_resp_vld && tag_empty)
  );

endmodule

// File: tb/tb_softmax_dat_feeder.sv
// Randomised bench for softmax_dat_feeder against a nested-loop walk
// model with an in-order memory responder.
module tb_softmax_dat_feeder;
  localparam int DAT_DW     = 16;
  localparam int TOUT       = 8;
  localparam int BURST_LEN  = 8;
  localparam int LOG2_BURST = 3;
  localparam int CH_W       = 12;
  localparam int PIX_W      = 16;
  localparam int AW         = 32;
  localparam int OUTSTD     = 4;
  localparam int DW         = DAT_DW * TOUT;

  typedef struct packed {
    logic [AW-1:0]         addr;
    logic [LOG2_BURST-1:0] lane;
    logic [CH_W-1:0]       cg;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [AW-1:0]    base_addr;
  logic [CH_W-1:0]  ch_in;
  logic [PIX_W-1:0] pixel_num;
  logic             busy;
  logic             done;

  softmax_dat_feeder_if #(
    .DAT_DW(DAT_DW), .TOUT(TOUT), .LOG2_BURST(LOG2_BURST),
    .CH_W(CH_W), .AW(AW)
  ) bus ();

  softmax_dat_feeder #(
    .DAT_DW(DAT_DW), .TOUT(TOUT), .BURST_LEN(BURST_LEN),
    .LOG2_BURST(LOG2_BURST), .CH_W(CH_W), .PIX_W(PIX_W),
    .AW(AW), .OUTSTD(OUTSTD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_addr(base_addr),
    .ch_in(ch_in),
    .pixel_num(pixel_num),
    .busy(busy),
    .done(done),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  int checks;
  int failures;
  exp_t exp_req[$];
  exp_t exp_beat[$];
  logic [AW-1:0] rq[$];
  int outst;
  logic taken;
  int total_req, total_beat;
  int nreq, nbeat, first_beat, last_beat;
  int stall_seen, full_seen, ostall_seen;
  logic got_done;

  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    logic [DW-1:0] r;
    for (int i = 0; i < TOUT; i++)
      r[i*DAT_DW +: DAT_DW] = a[15:0] ^ a[31:16] ^
                              16'(i * 16'h1357 + 16'h0F0F);
    return r;
  endfunction

  task automatic build_model(input logic [AW-1:0] b,
                             input int ch, input int pn);
    int chg, ng;
    exp_t e;
    exp_req.delete();
    exp_beat.delete();
    if (ch != 0 && pn != 0) begin
      chg = (ch + TOUT - 1) / TOUT;
      ng  = (pn + BURST_LEN - 1) / BURST_LEN;
      for (int g = 0; g < ng; g++)
        for (int c = 0; c < chg; c++)
          for (int p = 0; p < BURST_LEN; p++)
            if (g * BURST_LEN + p < pn) begin
              e.addr = b + AW'(c * pn + g * BURST_LEN + p);
              e.lane = LOG2_BURST'(p);
              e.cg   = CH_W'(c);
              exp_req.push_back(e);
              exp_beat.push_back(e);
            end
    end
    total_req  = exp_req.size();
    total_beat = exp_beat.size();
  endtask

  task automatic run_job(input logic [AW-1:0] b, input int ch,
                         input int pn, input int req_pct,
                         input int out_pct, input int resp_pct,
                         input int hold, input bit busy_start,
                         input bit abort);
    logic ps_req, ps_out, stop;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_dat;
    logic [LOG2_BURST-1:0] p_wr;
    logic [CH_W-1:0] p_ch;
    exp_t e;
    build_model(b, ch, pn);
    rq.delete();
    outst = 0; taken = 0;
    nreq = 0; nbeat = 0; first_beat = -1; last_beat = -1;
    stall_seen = 0; full_seen = 0; ostall_seen = 0;
    got_done = 0; stop = 0; ps_req = 0; ps_out = 0;
    p_addr = '0; p_dat = '0; p_wr = '0; p_ch = '0;
    @(negedge clk);
    start = 1; base_addr = b;
    ch_in = CH_W'(ch); pixel_num = PIX_W'(pn);
    @(negedge clk);
    base_addr = $urandom;
    ch_in = CH_W'($urandom);
    pixel_num = PIX_W'($urandom);
    for (int cyc = 0; cyc < 5000 && !got_done && !stop; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (taken) begin
        bus.rd_resp_vld = 0;
        taken = 0;
      end
      bus.rd_req_rdy = (cyc < hold) ? 1'b0 :
                       ($urandom_range(0, 99) < req_pct);
      bus.dat_out_rdy = ($urandom_range(0, 99) < out_pct);
      start = busy_start && cyc == 3 && exp_beat.size() > 2;
      if (!bus.rd_resp_vld && rq.size() > 0 &&
          $urandom_range(0, 99) < resp_pct) begin
        bus.rd_resp_vld = 1;
        bus.rd_resp_dat = mem(rq[0]);
      end
      #1;
      if (cyc == 0) begin
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL busy_start: got %b want 1", busy);
        end
      end
      if (outst == OUTSTD) begin
        full_seen++;
        checks++;
        if (bus.rd_req_vld !== 1'b0) begin
          failures++;
          $display("FAIL vld_full: got %b want 0", bus.rd_req_vld);
        end
      end
      if (ps_req) begin
        stall_seen++;
        checks++;
        if (bus.rd_req_vld !== 1'b1 || bus.rd_req_addr !== p_addr) begin
          failures++;
          $display("FAIL req_hold: got %b/%h want 1/%h",
                   bus.rd_req_vld, bus.rd_req_addr, p_addr);
        end
      end
      if (ps_out) begin
        ostall_seen++;
        checks++;
        if (bus.dat_out_vld !== 1'b1 || bus.dat_out !== p_dat ||
            bus.wr_addr !== p_wr || bus.ch_addr !== p_ch) begin
          failures++;
          $display("FAIL out_hold: got %h/%h want %h/%h",
                   bus.wr_addr, bus.ch_addr, p_wr, p_ch);
        end
      end
      if (bus.rd_req_vld && bus.rd_req_rdy) begin
        checks++;
        if (exp_req.size() == 0) begin
          failures++;
          $display("FAIL extra_req: got %h want none",
                   bus.rd_req_addr);
        end else begin
          e = exp_req.pop_front();
          if (bus.rd_req_addr !== e.addr) begin
            failures++;
            $display("FAIL req_addr: got %h want %h",
                     bus.rd_req_addr, e.addr);
          end
        end
        rq.push_back(bus.rd_req_addr);
        nreq++;
        outst++;
      end
      if (bus.rd_resp_vld && bus.rd_resp_rdy) begin
        void'(rq.pop_front());
        taken = 1;
        outst--;
      end
      if (bus.dat_out_vld && bus.dat_out_rdy) begin
        checks++;
        if (exp_beat.size() == 0) begin
          failures++;
          $display("FAIL extra_beat: got %h/%h want none",
                   bus.wr_addr, bus.ch_addr);
        end else begin
          e = exp_beat.pop_front();
          if (bus.dat_out !== mem(e.addr) || bus.wr_addr !== e.lane ||
              bus.ch_addr !== e.cg) begin
            failures++;
            $display("FAIL beat: got %h/%h/%h want %h/%h/%h",
                     bus.wr_addr, bus.ch_addr, bus.dat_out[15:0],
                     e.lane, e.cg, mem(e.addr)[15:0]);
          end
        end
        nbeat++;
        if (first_beat < 0) first_beat = cyc;
        last_beat = cyc;
      end
      ps_req = bus.rd_req_vld && !bus.rd_req_rdy;
      p_addr = bus.rd_req_addr;
      ps_out = bus.dat_out_vld && !bus.dat_out_rdy;
      p_dat  = bus.dat_out;
      p_wr   = bus.wr_addr;
      p_ch   = bus.ch_addr;
      if (done) begin
        got_done = 1;
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("FAIL busy_at_done: got %b want 0", busy);
        end
      end
      if (abort && nreq == total_req) stop = 1;
    end
    start = 0;
    if (!abort) begin
      checks++;
      if (!got_done) begin
        failures++;
        $display("FAIL done_timeout: got 0 want 1");
      end
      checks++;
      if (nreq != total_req) begin
        failures++;
        $display("FAIL req_count: got %0d want %0d", nreq, total_req);
      end
      checks++;
      if (nbeat != total_beat) begin
        failures++;
        $display("FAIL beat_count: got %0d want %0d", nbeat, total_beat);
      end
      @(negedge clk);
      if (taken) begin
        bus.rd_resp_vld = 0;
        taken = 0;
      end
      #1;
      checks++;
      if (done !== 1'b0) begin
        failures++;
        $display("FAIL done_pulse: got %b want 0", done);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 0 || done !== 0 || bus.rd_req_vld !== 0 ||
        bus.dat_out_vld !== 0 || bus.rd_req_addr !== '0 ||
        bus.dat_out !== '0 || bus.wr_addr !== '0 ||
        bus.ch_addr !== '0) begin
      failures++;
      $display("FAIL reset: got %b%b%b%b want 0000",
               busy, done, bus.rd_req_vld, bus.dat_out_vld);
    end
  endtask

  task automatic test_basic();
    run_job(32'h100, 16, 8, 100, 100, 100, 0, 0, 0);
    checks++;
    if (last_beat - first_beat != 15) begin
      failures++;
      $display("FAIL throughput: got %0d want 15",
               last_beat - first_beat);
    end
  endtask

  task automatic test_partial();
    run_job($urandom, 8, 10, 100, 100, 100, 0, 0, 0);
    checks++;
    if (nbeat != 10) begin
      failures++;
      $display("FAIL partial_beats: got %0d want 10", nbeat);
    end
  endtask

  task automatic test_req_stall();
    run_job($urandom, 16, 12, 100, 100, 10, 5, 0, 0);
    checks++;
    if (stall_seen < 5 || full_seen == 0) begin
      failures++;
      $display("FAIL stall_cover: got %0d/%0d want >=5/>0",
               stall_seen, full_seen);
    end
  endtask

  task automatic test_out_backpressure();
    run_job($urandom, 24, 13, 70, 40, 70, 0, 1, 0);
    checks++;
    if (ostall_seen == 0) begin
      failures++;
      $display("FAIL ostall_cover: got 0 want >0");
    end
  endtask

  task automatic test_zero(input int ch, input int pn);
    @(negedge clk);
    start = 1; base_addr = $urandom;
    ch_in = CH_W'(ch); pixel_num = PIX_W'(pn);
    @(negedge clk);
    ch_in = 8; pixel_num = 8;
    #1;
    checks++;
    if (busy !== 1 || done !== 0 || bus.rd_req_vld !== 0) begin
      failures++;
      $display("FAIL zero_c1: got %b%b%b want 100",
               busy, done, bus.rd_req_vld);
    end
    @(negedge clk);
    start = 0;
    #1;
    checks++;
    if (busy !== 0 || done !== 1 || bus.rd_req_vld !== 0) begin
      failures++;
      $display("FAIL zero_c2: got %b%b%b want 010",
               busy, done, bus.rd_req_vld);
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 0 || done !== 0 || bus.rd_req_vld !== 0) begin
      failures++;
      $display("FAIL zero_c3: got %b%b%b want 000",
               busy, done, bus.rd_req_vld);
    end
  endtask

  task automatic test_reset_mid();
    run_job($urandom, 16, 16, 100, 20, 5, 0, 0, 1);
    @(negedge clk);
    rst = 1;
    bus.rd_resp_vld = 0;
    rq.delete();
    outst = 0;
    taken = 0;
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 0 || done !== 0 || bus.rd_req_vld !== 0 ||
        bus.dat_out_vld !== 0 || bus.dat_out !== '0 ||
        bus.wr_addr !== '0 || bus.ch_addr !== '0 ||
        bus.rd_req_addr !== '0) begin
      failures++;
      $display("FAIL mid_reset: got %b%b%b%b want 0000",
               busy, done, bus.rd_req_vld, bus.dat_out_vld);
    end
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (done !== 0 || busy !== 0) begin
        failures++;
        $display("FAIL post_reset: got %b%b want 00", done, busy);
      end
    end
    run_job($urandom, 9, 11, 80, 80, 80, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [AW-1:0] b;
    for (int it = 0; it < 6; it++) begin
      b = (it == 0) ? 32'hFFFF_FFF0 : $urandom;
      run_job(b, $urandom_range(1, 40), $urandom_range(1, 30),
              $urandom_range(30, 100), $urandom_range(30, 100),
              $urandom_range(20, 100), 0, 1, 0);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1;
    start = 0;
    base_addr = '0;
    ch_in = '0;
    pixel_num = '0;
    bus.rd_req_rdy = 0;
    bus.rd_resp_vld = 0;
    bus.rd_resp_dat = '0;
    bus.dat_out_rdy = 0;
    taken = 0;
    outst = 0;
    test_reset();
    test_basic();
    test_partial();
    test_req_stall();
    test_out_backpressure();
    test_zero(0, 8);
    test_zero(16, 0);
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
